module_keypad_reader: RTL and testbench
=======================================

MODULE_KEYPAD_READER -- requirements
Module: module_keypad_reader

Interface
REQ-001 SHALL have parameter SCAN_PERIOD, default 27000: clocks per scan tick; minimum value 2.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 4: consecutive stable ticks required to accept a press or a release; minimum value 1.
REQ-003 SHALL have port clk_i, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port fila_i, input, 4 bits: keypad rows; active-low, externally pulled up, asynchronous to clk_i.
REQ-006 SHALL have port columna_o, output, 4 bits: column drive; active-low, one-hot.
REQ-007 SHALL have port key_code_o, output, 4 bits: code of the last accepted key.
REQ-008 SHALL have port key_valid_o, output, 1 bit: one-clock pulse for each accepted key press.
REQ-009 SHALL have port entry_o, output, 16 bits: binary value of the number currently being typed.
REQ-010 SHALL have port digitos_o, output, 2 bits: count of digits entered, 0 to 3.
REQ-011 SHALL have port valor_o, output, 16 bits: last committed binary value; drives the display driver bin_i directly.
REQ-012 SHALL have port valid_o, output, 1 bit: one-clock pulse when valor_o is updated.

Function
REQ-013 SHALL pass fila_i through a 2-flop synchronizer; only the synchronized rows are used internally.
REQ-014 SHALL generate a one-clock tick every SCAN_PERIOD clocks from a free-running down-counter.
REQ-015 SHALL use a four-state FSM with states SCAN, DEBOUNCE, HOLD and RELEASE.
REQ-016 In SCAN, when a tick occurs and all rows are high, SHALL rotate the active column 0->1->2->3->0 (columna_o 1110->1101->1011->0111->1110).
REQ-017 In SCAN, when a tick occurs and any row is low, SHALL freeze the column, latch the row pattern and go to DEBOUNCE.
REQ-018 In DEBOUNCE, SHALL check the rows on each tick:
- same pattern: increment the stable count;
- all rows high: return to SCAN and resume rotation;
- different nonzero pattern: re-latch the pattern and restart the count at 1.
REQ-019 On reaching DEBOUNCE_TICKS stable ticks, SHALL go to HOLD and pulse key_valid_o for exactly one clock with key_code_o updated on that same clock.
REQ-020 If several rows are low at once, the lowest-index low row SHALL win.
REQ-021 SHALL decode keys by (row, column):
- row 0: 1, 2, 3, A
- row 1: 4, 5, 6, B
- row 2: 7, 8, 9, C
- row 3: *, 0, #, D
- codes: digits 0-9 = 4'h0-4'h9; A-D = 4'hA-4'hD; * = 4'hE (clear); # = 4'hF (enter).
REQ-022 HOLD SHALL NOT emit further pulses while the key is held; it SHALL go to RELEASE on the first tick with all rows high.
REQ-023 RELEASE SHALL require DEBOUNCE_TICKS consecutive all-high ticks before returning to SCAN; any low row SHALL send it back to HOLD.
REQ-024 On a digit key d with digitos_o<3, SHALL set entry_o <= entry_o*10 + d and increment digitos_o, both in the clock after the key_valid_o pulse.
REQ-025 On a digit key with digitos_o==3, SHALL leave entry_o and digitos_o unchanged.
REQ-026 On * (4'hE), SHALL set entry_o=0 and digitos_o=0; valor_o SHALL be unchanged.
REQ-027 On # (4'hF), SHALL set valor_o=entry_o, pulse valid_o for one clock, and set entry_o=0 and digitos_o=0, all on the same clock.
REQ-028 On # with digitos_o==0, SHALL commit valor_o=0 and still pulse valid_o.
REQ-029 Keys A-D SHALL pulse key_valid_o but SHALL NOT change entry_o, digitos_o or valor_o.
REQ-030 Width rules: entry_o never exceeds 999; the arithmetic SHALL be unsigned, the *10 SHALL be implemented as shift-add, and bits [15:10] of entry_o and valor_o SHALL always be 0.

Reset
REQ-031 While rst_i=0, all state SHALL clear asynchronously:
- FSM=SCAN, columna_o=4'b1110, tick counter=SCAN_PERIOD-1;
- key_code_o=0, key_valid_o=0, entry_o=0, digitos_o=0, valor_o=0, valid_o=0;
- synchronizer flops=4'b1111.
REQ-032 Reset asserted mid-debounce or mid-hold SHALL discard the pending key; no pulse SHALL occur on or after reset release until a new full debounce completes.

Verification (SCAN_PERIOD=4, DEBOUNCE_TICKS=2)
REQ-033 Idle rows=1111 -> columna_o cycles 1110,1101,1011,0111 with each value held 4 clocks; key_valid_o stays 0.
REQ-034 Press 1, 2, 3 then # (each debounced, then released) -> entry_o goes 1, 12, 123; then valor_o=123, valid_o pulses once, entry_o=0, digitos_o=0.
REQ-035 Press 9, 9, 9, 5 -> entry_o=999 and digitos_o=3 after the third 9; the 5 is ignored; # then gives valor_o=999.
REQ-036 Glitch: row 0 low for 1 tick only -> no key_valid_o; key 5 held for 20 ticks -> exactly one key_valid_o with key_code_o=4'h5.
REQ-037 Row0 and row2 low together on column 1 -> key_code_o=4'h2; enter 45 then * -> entry_o=0 and valor_o unchanged.
REQ-038 Assert rst_i during HOLD of key 7 -> all outputs return to reset values; after release no key_valid_o occurs while the key stays held until a fresh debounce completes.

Source files
------------

// File: rtl/module_keypad_reader.sv
// 4x4 matrix keypad scanner with debounce and a 3-digit decimal entry/commit stage.
// key_valid_o pulses once per debounced press; the digit datapath reacts one clock later.
module module_keypad_reader #(
  parameter int SCAN_PERIOD    = 27000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  fila_i,
  output logic [3:0]  columna_o,
  output logic [3:0]  key_code_o,
  output logic        key_valid_o,
  output logic [15:0] entry_o,
  output logic [1:0]  digitos_o,
  output logic [15:0] valor_o,
  output logic        valid_o
);

  localparam int CW = $clog2(SCAN_PERIOD);
  localparam int SW = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] DT_M1   = SW'(DEBOUNCE_TICKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    col_q, col_d;
  logic [3:0]    pat_q, pat_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic [9:0]    entry_q, entry_d;
  logic [1:0]    dig_q, dig_d;
  logic [9:0]    valor_q, valor_d;
  logic          valid_q, valid_d;
  logic          tick, all_high;

  assign tick     = (cnt_q == '0);
  assign all_high = &sync2_q;

  // Lowest-index low row wins when several rows are pulled down together.
  function automatic logic [3:0] decode(input logic [3:0] pat, input logic [1:0] col);
    logic [1:0] r;
    logic [3:0] code;
    r = 2'd3;
    if (!pat[2]) r = 2'd2;
    if (!pat[1]) r = 2'd1;
    if (!pat[0]) r = 2'd0;
    case ({r, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    pat_d       = pat_q;
    stab_d      = stab_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (all_high) begin
            col_d = col_q + 2'd1;
          end else begin
            pat_d  = sync2_q;
            stab_d = SW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              state_d     = HOLD;
              key_valid_d = 1'b1;
              key_code_d  = decode(sync2_q, col_q);
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (all_high) begin
            state_d = SCAN;
          end else if (sync2_q != pat_q) begin
            pat_d  = sync2_q;
            stab_d = SW'(1);
          end else if (stab_q == DT_M1) begin
            state_d     = HOLD;
            key_valid_d = 1'b1;
            key_code_d  = decode(sync2_q, col_q);
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
        HOLD: begin
          if (all_high) begin
            stab_d  = SW'(1);
            state_d = (DEBOUNCE_TICKS == 1) ? SCAN : RELEASE;
          end
        end
        default: begin
          if (!all_high) begin
            state_d = HOLD;
          end else if (stab_q == DT_M1) begin
            state_d = SCAN;
          end else begin
            stab_d = stab_q + SW'(1);
          end
        end
      endcase
    end
  end

  // Entry stays below 1000, so a 10-bit register with *10 as (x<<3)+(x<<1) cannot overflow.
  always_comb begin
    entry_d = entry_q;
    dig_d   = dig_q;
    valor_d = valor_q;
    valid_d = 1'b0;
    if (key_valid_q) begin
      if (key_code_q <= 4'h9) begin
        if (dig_q != 2'd3) begin
          entry_d = {entry_q[6:0], 3'b000} + {entry_q[8:0], 1'b0} + {6'b0, key_code_q};
          dig_d   = dig_q + 2'd1;
        end
      end else if (key_code_q == 4'hE) begin
        entry_d = '0;
        dig_d   = '0;
      end else if (key_code_q == 4'hF) begin
        valor_d = entry_q;
        valid_d = 1'b1;
        entry_d = '0;
        dig_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      cnt_q       <= CNT_MAX;
      state_q     <= SCAN;
      col_q       <= '0;
      pat_q       <= 4'hF;
      stab_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      entry_q     <= '0;
      dig_q       <= '0;
      valor_q     <= '0;
      valid_q     <= 1'b0;
    end else begin
      sync1_q     <= fila_i;
      sync2_q     <= sync1_q;
      cnt_q       <= tick ? CNT_MAX : cnt_q - CW'(1);
      state_q     <= state_d;
      col_q       <= col_d;
      pat_q       <= pat_d;
      stab_q      <= stab_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      entry_q     <= entry_d;
      dig_q       <= dig_d;
      valor_q     <= valor_d;
      valid_q     <= valid_d;
    end
  end

  assign columna_o   = ~(4'b0001 << col_q);
  assign key_code_o  = key_code_q;
  assign key_valid_o = key_valid_q;
  assign entry_o     = {6'b0, entry_q};
  assign digitos_o   = dig_q;
  assign valor_o     = {6'b0, valor_q};
  assign valid_o     = valid_q;

endmodule

// File: tb/tb_module_keypad_reader.sv
// Directed bench: a keypad model turns pressed-key masks and the column drive into row levels.
module tb_module_keypad_reader;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  fila_i;
  logic [3:0]  columna_o, key_code_o;
  logic        key_valid_o, valid_o;
  logic [15:0] entry_o, valor_o;
  logic [1:0]  digitos_o;

  logic [15:0] mask   = '0;
  logic [3:0]  glitch = '0;
  int vecs = 0;
  int errs = 0;

  module_keypad_reader #(.SCAN_PERIOD(4), .DEBOUNCE_TICKS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fila_i(fila_i), .columna_o(columna_o),
    .key_code_o(key_code_o), .key_valid_o(key_valid_o), .entry_o(entry_o),
    .digitos_o(digitos_o), .valor_o(valor_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  // A pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    fila_i = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[r*4+c] && !columna_o[c]) fila_i[r] = 1'b0;
    fila_i = fila_i & ~glitch;
  end

  function automatic logic [15:0] kmask(input logic [3:0] k);
    int idx;
    case (k)
      4'h1: idx = 0;  4'h2: idx = 1;  4'h3: idx = 2;  4'hA: idx = 3;
      4'h4: idx = 4;  4'h5: idx = 5;  4'h6: idx = 6;  4'hB: idx = 7;
      4'h7: idx = 8;  4'h8: idx = 9;  4'h9: idx = 10; 4'hC: idx = 11;
      4'hE: idx = 12; 4'h0: idx = 13; 4'hF: idx = 14; default: idx = 15;
    endcase
    return 16'h0001 << idx;
  endfunction

  // Press a mask for `hold` clocks, release for 40, counting output pulses throughout.
  task automatic tap(input logic [15:0] m, input int hold, output int kp, output int vp,
                     output logic [3:0] code);
    kp = 0; vp = 0; code = 4'hx;
    mask = m;
    repeat (hold) begin
      @(negedge clk_i);
      if (key_valid_o) begin kp++; code = key_code_o; end
      if (valid_o) vp++;
    end
    mask = '0;
    repeat (40) begin
      @(negedge clk_i);
      if (key_valid_o) begin kp++; code = key_code_o; end
      if (valid_o) vp++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_i);
    vecs++; if (columna_o !== 4'b1110) begin errs++; $display("FAIL reset columna got %b expected 1110", columna_o); end
    vecs++; if (key_code_o !== 4'h0) begin errs++; $display("FAIL reset key_code got %h expected 0", key_code_o); end
    vecs++; if (key_valid_o !== 1'b0) begin errs++; $display("FAIL reset key_valid got %b expected 0", key_valid_o); end
    vecs++; if (entry_o !== 16'd0) begin errs++; $display("FAIL reset entry got %0d expected 0", entry_o); end
    vecs++; if (digitos_o !== 2'd0) begin errs++; $display("FAIL reset digitos got %0d expected 0", digitos_o); end
    vecs++; if (valor_o !== 16'd0) begin errs++; $display("FAIL reset valor got %0d expected 0", valor_o); end
    vecs++; if (valid_o !== 1'b0) begin errs++; $display("FAIL reset valid got %b expected 0", valid_o); end
  endtask

  task automatic test_idle_scan;
    logic [3:0] e;
    rst_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk_i); #1;
      e = ~(4'b0001 << ((k / 4) % 4));
      vecs++; if (columna_o !== e || key_valid_o !== 1'b0) begin
        errs++; $display("FAIL idle clk %0d columna %b kv %b expected %b kv 0", k, columna_o, key_valid_o, e);
      end
    end
  endtask

  task automatic test_digits;
    logic [3:0] ks[4];
    int ent[4], dg[4], vl[4], vpx[4];
    int kp, vp;
    logic [3:0] code;
    ks = '{4'h1, 4'h2, 4'h3, 4'hF};
    ent = '{1, 12, 123, 0}; dg = '{1, 2, 3, 0}; vl = '{0, 0, 0, 123}; vpx = '{0, 0, 0, 1};
    for (int i = 0; i < 4; i++) begin
      tap(kmask(ks[i]), 60, kp, vp, code);
      vecs++; if (kp !== 1 || code !== ks[i]) begin errs++; $display("FAIL digits step %0d pulses %0d code %h expected 1 code %h", i, kp, code, ks[i]); end
      vecs++; if (entry_o !== 16'(ent[i]) || digitos_o !== 2'(dg[i])) begin errs++; $display("FAIL digits step %0d entry %0d dig %0d expected %0d %0d", i, entry_o, digitos_o, ent[i], dg[i]); end
      vecs++; if (valor_o !== 16'(vl[i]) || vp !== vpx[i]) begin errs++; $display("FAIL digits step %0d valor %0d valid %0d expected %0d %0d", i, valor_o, vp, vl[i], vpx[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [3:0] ks[5];
    int ent[5], dg[5], vl[5], vpx[5];
    int kp, vp;
    logic [3:0] code;
    ks = '{4'h9, 4'h9, 4'h9, 4'h5, 4'hF};
    ent = '{9, 99, 999, 999, 0}; dg = '{1, 2, 3, 3, 0};
    vl = '{123, 123, 123, 123, 999}; vpx = '{0, 0, 0, 0, 1};
    for (int i = 0; i < 5; i++) begin
      tap(kmask(ks[i]), 60, kp, vp, code);
      vecs++; if (kp !== 1 || code !== ks[i]) begin errs++; $display("FAIL overflow step %0d pulses %0d code %h expected 1 code %h", i, kp, code, ks[i]); end
      vecs++; if (entry_o !== 16'(ent[i]) || digitos_o !== 2'(dg[i])) begin errs++; $display("FAIL overflow step %0d entry %0d dig %0d expected %0d %0d", i, entry_o, digitos_o, ent[i], dg[i]); end
      vecs++; if (valor_o !== 16'(vl[i]) || vp !== vpx[i]) begin errs++; $display("FAIL overflow step %0d valor %0d valid %0d expected %0d %0d", i, valor_o, vp, vl[i], vpx[i]); end
    end
  endtask

  task automatic test_glitch;
    int kp, vp;
    logic [3:0] code;
    @(negedge clk_i);
    glitch = 4'b0001;
    repeat (3) @(negedge clk_i);
    glitch = '0;
    tap('0, 0, kp, vp, code);
    vecs++; if (kp !== 0) begin errs++; $display("FAIL glitch pulses %0d expected 0", kp); end
    tap(kmask(4'h5), 80, kp, vp, code);
    vecs++; if (kp !== 1 || code !== 4'h5) begin errs++; $display("FAIL long_hold pulses %0d code %h expected 1 code 5", kp, code); end
    vecs++; if (entry_o !== 16'd5 || digitos_o !== 2'd1) begin errs++; $display("FAIL long_hold entry %0d dig %0d expected 5 1", entry_o, digitos_o); end
  endtask

  task automatic test_multi_clear;
    logic [15:0] ms[7];
    logic [3:0] cs[7];
    int ent[7], dg[7], vl[7], vpx[7];
    int kp, vp;
    logic [3:0] code;
    ms = '{kmask(4'h2) | kmask(4'h8), kmask(4'hE), kmask(4'h4), kmask(4'h5),
           kmask(4'hA), kmask(4'hE), kmask(4'hF)};
    cs = '{4'h2, 4'hE, 4'h4, 4'h5, 4'hA, 4'hE, 4'hF};
    ent = '{52, 0, 4, 45, 45, 0, 0}; dg = '{2, 0, 1, 2, 2, 0, 0};
    vl = '{999, 999, 999, 999, 999, 999, 0}; vpx = '{0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      tap(ms[i], 60, kp, vp, code);
      vecs++; if (kp !== 1 || code !== cs[i]) begin errs++; $display("FAIL multi step %0d pulses %0d code %h expected 1 code %h", i, kp, code, cs[i]); end
      vecs++; if (entry_o !== 16'(ent[i]) || digitos_o !== 2'(dg[i])) begin errs++; $display("FAIL multi step %0d entry %0d dig %0d expected %0d %0d", i, entry_o, digitos_o, ent[i], dg[i]); end
      vecs++; if (valor_o !== 16'(vl[i]) || vp !== vpx[i]) begin errs++; $display("FAIL multi step %0d valor %0d valid %0d expected %0d %0d", i, valor_o, vp, vl[i], vpx[i]); end
    end
  endtask

  task automatic test_reset_hold;
    int kp, n;
    logic [3:0] code;
    mask = kmask(4'h7);
    n = 0;
    while (key_valid_o !== 1'b1 && n < 100) begin @(negedge clk_i); n++; end
    vecs++; if (key_valid_o !== 1'b1) begin errs++; $display("FAIL rst_hold first press timeout kv %b expected 1", key_valid_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    vecs++; if (columna_o !== 4'b1110 || key_code_o !== 4'h0 || key_valid_o !== 1'b0) begin
      errs++; $display("FAIL rst_hold scan outs col %b code %h kv %b expected 1110 0 0", columna_o, key_code_o, key_valid_o); end
    vecs++; if (entry_o !== 16'd0 || digitos_o !== 2'd0 || valor_o !== 16'd0 || valid_o !== 1'b0) begin
      errs++; $display("FAIL rst_hold data outs entry %0d dig %0d valor %0d valid %b expected 0 0 0 0", entry_o, digitos_o, valor_o, valid_o); end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    kp = 0;
    repeat (6) begin @(negedge clk_i); if (key_valid_o) kp++; end
    vecs++; if (kp !== 0) begin errs++; $display("FAIL rst_hold early pulses %0d expected 0", kp); end
    code = 4'hx;
    repeat (60) begin @(negedge clk_i); if (key_valid_o) begin kp++; code = key_code_o; end end
    vecs++; if (kp !== 1 || code !== 4'h7) begin errs++; $display("FAIL rst_hold fresh pulses %0d code %h expected 1 code 7", kp, code); end
    vecs++; if (entry_o !== 16'd7) begin errs++; $display("FAIL rst_hold entry %0d expected 7", entry_o); end
    mask = '0;
    repeat (40) @(negedge clk_i);
  endtask

  initial begin
    test_reset;
    test_idle_scan;
    test_digits;
    test_overflow;
    test_glitch;
    test_multi_clear;
    test_reset_hold;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
